// File: rtl/apb_timer_arbiter.sv
// Round-robin arbiter that funnels NREQ requesters onto a single APB timer slave,
// one transfer at a time, with an optional ACCESS-phase wait timeout.
module apb_timer_arbiter #(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NREQ-1:0]                req_i,
  input  logic [NREQ-1:0]                we_i,
  input  logic [NREQ*APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [NREQ*32-1:0]             wdata_i,
  output logic [NREQ-1:0]                gnt_o,
  output logic [NREQ-1:0]                rsp_valid_o,
  output logic [31:0]                    rsp_rdata_o,
  output logic                           rsp_err_o,
  output logic [APB_ADDR_WIDTH-1:0]      PADDR,
  output logic [31:0]                    PWDATA,
  output logic                           PWRITE,
  output logic                           PSEL,
  output logic                           PENABLE,
  input  logic [31:0]                    PRDATA,
  input  logic                           PREADY,
  input  logic                           PSLVERR
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned SW = IW + 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       ptr_nxt;
  logic [IW-1:0]       win;
  logic [IW-1:0]       idx;
  logic                found;
  logic                grant;
  logic                tmo;
  logic [CW-1:0]       cnt;
  logic [2*NREQ-1:0]   req_dbl;
  logic [NREQ-1:0]     req_rot;
  logic [SW-1:0]       sum;
  logic [SW-1:0]       sum_nxt;

  // Rotate requests so bit 0 is the requester at ptr; first set bit wins.
  always_comb begin
    req_dbl = {req_i, req_i} >> ptr;
    req_rot = req_dbl[NREQ-1:0];
    found   = 1'b0;
    win     = '0;
    sum     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        sum   = SW'(ptr) + SW'(i);
        if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
        win   = sum[IW-1:0];
      end
    end
    sum_nxt = SW'(win) + SW'(1);
    if (sum_nxt >= SW'(NREQ)) sum_nxt = '0;
    ptr_nxt = sum_nxt[IW-1:0];
  end

  assign grant = (state == IDLE) && found;
  assign tmo   = (TIMEOUT != 0) && !PREADY && ((32'(cnt) + 32'd1) >= TIMEOUT);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is combinational so a request in IDLE is accepted in the same cycle.
  always_comb begin
    gnt_o   = '0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    case (state)
      IDLE:    if (found && !HRESET) gnt_o = NREQ'(1) << win;
      SETUP:   PSEL = 1'b1;
      ACCESS:  begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ptr         <= '0;
      idx         <= '0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      cnt         <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      if (grant) begin
        ptr    <= ptr_nxt;
        idx    <= win;
        PWRITE <= we_i[win];
        PADDR  <= addr_i[win*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        PWDATA <= we_i[win] ? wdata_i[win*DW +: DW] : '0;
      end
      // Wait counter saturates rather than wrapping when TIMEOUT is disabled.
      if (state == SETUP) cnt <= '0;
      else if (state == ACCESS && !PREADY && !(&cnt)) cnt <= cnt + CW'(1);
      if (state == ACCESS && (PREADY || tmo)) begin
        rsp_valid_o <= NREQ'(1) << idx;
        rsp_rdata_o <= (PREADY && !PWRITE) ? PRDATA : '0;
        rsp_err_o   <= PREADY ? PSLVERR : 1'b1;
      end
    end
  end

endmodule

// File: doc/apb_timer_arbiter.md
APB_TIMER_ARBITER -- requirements
Module: apb_timer_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (2..8).
REQ-002 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, max ACCESS wait cycles (0 = no timeout).
REQ-004 SHALL have port HCLK  input  1  single clock, all logic rising-edge.
REQ-005 SHALL have port HRESET  input  1  asynchronous active-high reset.
REQ-006 SHALL have port req_i  input  NREQ  per-requester transfer request, held until granted.
REQ-007 SHALL have port we_i  input  NREQ  per-requester write (1) / read (0).
REQ-008 SHALL have port addr_i  input  NREQ*APB_ADDR_WIDTH  packed per-requester addresses, requester k at slice k.
REQ-009 SHALL have port wdata_i  input  NREQ*32  packed per-requester write data.
REQ-010 SHALL have port gnt_o  output  NREQ  one-hot one-cycle accept pulse.
REQ-011 SHALL have port rsp_valid_o  output  NREQ  one-hot one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata_o  output  32  read data, valid with rsp_valid_o.
REQ-013 SHALL have port rsp_err_o  output  1  slave error or timeout, valid with rsp_valid_o.
REQ-014 SHALL have ports PADDR (APB_ADDR_WIDTH), PWDATA (32), PWRITE, PSEL, PENABLE as outputs to the timer APB slave.
REQ-015 SHALL have ports PRDATA (32), PREADY, PSLVERR as inputs from the timer APB slave.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-017 In IDLE with any req_i set, SHALL combinationally assert gnt_o for the winner and move to SETUP next cycle; with no request, SHALL stay IDLE.
REQ-018 SHALL arbitrate round-robin: search starts at pointer ptr, first set req_i wins; on grant ptr <= winner+1 mod NREQ.
REQ-019 SHALL latch winner index, we, addr, wdata on the grant edge and drive PWRITE/PADDR/PWDATA from the latch; PWDATA SHALL be 0 for reads.
REQ-020 SETUP SHALL drive PSEL=1, PENABLE=0 for exactly one cycle, then go to ACCESS.
REQ-021 ACCESS SHALL drive PSEL=1, PENABLE=1 until PREADY=1 or timeout; address, data and PWRITE SHALL be stable throughout SETUP and ACCESS.
REQ-022 On PREADY=1 in ACCESS, SHALL go to IDLE and register rsp_valid_o[winner]=1, rsp_rdata_o=PRDATA (0 on writes), rsp_err_o=PSLVERR for one cycle.
REQ-023 Wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY=0; when TIMEOUT!=0 and counter reaches TIMEOUT, SHALL go to IDLE and respond rsp_err_o=1, rsp_rdata_o=0.
REQ-024 Counter width SHALL be $clog2(TIMEOUT+1); counter SHALL saturate, never wrap.
REQ-025 Completion cycle (IDLE with rsp_valid_o set) SHALL allow a new grant, giving 3 cycles minimum per transfer plus wait states.
REQ-026 Requests arriving outside IDLE SHALL be ignored until IDLE; gnt_o SHALL be 0 outside IDLE.
REQ-027 PREADY/PSLVERR/PRDATA SHALL be ignored outside ACCESS.
REQ-028 Deasserting req_i before grant SHALL cancel the request with no response.

Reset
REQ-029 HRESET=1 SHALL immediately force IDLE, ptr=0, counter=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, gnt_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
REQ-030 Reset during SETUP/ACCESS SHALL abort the transfer with no rsp_valid_o pulse.

Verification
REQ-031 Single write: req_i=01, we=1, addr=0x004, wdata=0xDEADBEEF, PREADY=1 -> gnt_o=01 cycle0, SETUP cycle1, ACCESS cycle2, rsp_valid_o=01 cycle3, rsp_err_o=0.
REQ-032 Contention: req_i=11 held continuously, ptr=0 -> grants 01,10,01,10 alternating, one per 3 cycles.
REQ-033 Wait states: read, PREADY low 5 cycles then high with PRDATA=0x12345678 -> ACCESS lasts 6 cycles, rsp_rdata_o=0x12345678.
REQ-034 Timeout: TIMEOUT=4, PREADY held 0 -> exit after 4 ACCESS cycles, rsp_err_o=1, rsp_rdata_o=0, PSEL drops.
REQ-035 Slave error: PSLVERR=1 with PREADY=1 -> rsp_err_o=1 on the completion pulse.
REQ-036 Reset in ACCESS: assert HRESET mid-ACCESS -> PSEL=0 same cycle, no rsp_valid_o, next grant goes to requester 0.
